// File: rtl/scalable_divider.sv
// Sequential radix-2 restoring unsigned divider, one quotient bit per clock, start/done handshake.
// Optional macro DIV_ZERO_DET_EN: B=0 short-circuits to DONE and raises div0.
module scalable_divider #(
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic                  ready,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] Q,
  output logic [DATA_WIDTH-1:0] R
`ifdef DIV_ZERO_DET_EN
  ,
  output logic                  div0
`endif
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          r_state, w_state_nx;
  logic [W-1:0]    r_q, r_b, r_rem, r_quo, r_res;
  logic [CW-1:0]   r_cnt;
  logic            w_accept, w_last;
  logic [W:0]      w_rem_sh;
  logic            w_ge;
  logic [W-1:0]    w_rem_nx, w_q_nx;
`ifdef DIV_ZERO_DET_EN
  logic            r_div0;
  logic            w_bzero;
  assign w_bzero = (B == '0);
  assign div0    = r_div0;
`endif

  // The stored remainder is always < B, so it fits in W bits; only the
  // shifted value needs the extra bit for the compare.
  assign w_rem_sh = {r_rem, r_q[W-1]};
  assign w_ge     = (w_rem_sh >= {1'b0, r_b});
  assign w_rem_nx = w_ge ? W'(w_rem_sh - {1'b0, r_b}) : w_rem_sh[W-1:0];
  assign w_q_nx   = {r_q[W-2:0], w_ge};
  assign w_last   = (r_cnt == CW'(1));

  assign ready = (r_state != S_BUSY);
  assign done  = (r_state == S_DONE);
  assign Q     = r_quo;
  assign R     = r_res;

  always_comb begin
    w_state_nx = r_state;
    w_accept   = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_accept   = 1'b1;
          w_state_nx = S_BUSY;
`ifdef DIV_ZERO_DET_EN
          if (w_bzero) w_state_nx = S_DONE;
`endif
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_BUSY:  if (w_last) w_state_nx = S_DONE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_q     <= '0;
      r_b     <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_quo   <= '0;
      r_res   <= '0;
`ifdef DIV_ZERO_DET_EN
      r_div0  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nx;
      if (w_accept) begin
        r_q   <= A;
        r_b   <= B;
        r_rem <= '0;
        r_cnt <= CW'(W);
`ifdef DIV_ZERO_DET_EN
        r_div0 <= w_bzero;
        if (w_bzero) begin
          r_quo <= '1;
          r_res <= A;
        end
`endif
      end else if (r_state == S_BUSY) begin
        r_q   <= w_q_nx;
        r_rem <= w_rem_nx;
        r_cnt <= r_cnt - CW'(1);
        // Results publish only on the last iteration, i.e. on entry to DONE.
        if (w_last) begin
          r_quo <= w_q_nx;
          r_res <= w_rem_nx;
        end
      end
    end
  end
endmodule

// File: tb/tb_scalable_divider.sv
// Scoreboard bench for scalable_divider (DATA_WIDTH=4): directed vectors, abort, sweep.
module tb_scalable_divider;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n, start;
  logic [W-1:0] A, B, Q, R;
  logic         ready, done;
`ifdef DIV_ZERO_DET_EN
  logic         div0;
`endif

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_done_abort = 0;
  bit   watch_abort = 1'b0;

  always #5 clk = ~clk;

  scalable_divider #(.DATA_WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .ready (ready),
    .done  (done),
    .Q     (Q),
    .R     (R)
`ifdef DIV_ZERO_DET_EN
    ,
    .div0  (div0)
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (watch_abort) n_done_abort++;
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got Q=%0d R=%0d expected no done", Q, R);
      end else begin
        exp_t e;
        e = sb.pop_front();
        n_vec++;
        if (Q !== e.q || R !== e.r) begin
          n_err++;
          $display("FAIL result: got Q=%0d R=%0d expected Q=%0d R=%0d", Q, R, e.q, e.r);
        end
`ifdef DIV_ZERO_DET_EN
        n_vec++;
        if (div0 !== e.dz) begin
          n_err++;
          $display("FAIL div0: got %0b expected %0b", div0, e.dz);
        end
`endif
      end
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ready === 1'b1) return;
    end
    chk("ready_timeout", 0, 1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) return;
    end
    chk("done_timeout", 0, 1);
  endtask

  // One division with latency and busy-window checks; the monitor checks values.
  task automatic do_div(input int a, input int b, input int eq, input int er,
                        input bit ez, input int exp_lat);
    exp_t e;
    int   lat, busy;
    wait_ready();
    A = W'(a); B = W'(b); start = 1'b1;
    e.q = W'(eq); e.r = W'(er); e.dz = ez;
    sb.push_back(e);
    @(posedge clk);
    lat = 0; busy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (lat == 0) start = 1'b0;
      lat++;
      if (done === 1'b1) break;
      if (ready === 1'b0) busy++;
    end
    if (exp_lat > 0) begin
      chk("latency", lat, exp_lat);
      chk("busy_cycles", busy, exp_lat - 1);
      chk("ready_at_done", int'(ready), 1);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", int'(ready), 1);
    chk("rst_done", int'(done), 0);
    chk("rst_Q", int'(Q), 0);
    chk("rst_R", int'(R), 0);
`ifdef DIV_ZERO_DET_EN
    chk("rst_div0", int'(div0), 0);
`endif
    rst_n = 1'b1;

    // Basic 13/3 with latency.
    do_div(13, 3, 4, 1, 1'b0, 5);
    // Divide by zero.
`ifdef DIV_ZERO_DET_EN
    do_div(9, 0, 15, 9, 1'b1, 1);
`else
    do_div(9, 0, 15, 9, 1'b0, 5);
`endif
    // Corner values; also clears div0 after the zero-divisor case.
    do_div(15, 1, 15, 0, 1'b0, 5);
    do_div(2, 7, 0, 2, 1'b0, 5);
    do_div(7, 7, 1, 0, 1'b0, 5);

    // Start mid-BUSY is ignored; start held into DONE is accepted back-to-back.
    begin
      exp_t e;
      wait_ready();
      A = 4'd13; B = 4'd3; start = 1'b1;
      e.q = 4'd4; e.r = 4'd1; e.dz = 1'b0; sb.push_back(e);
      @(posedge clk);
      @(negedge clk); start = 1'b0;
      @(negedge clk); A = 4'd6; B = 4'd2; start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk); start = 1'b1;
      e.q = 4'd3; e.r = 4'd0; e.dz = 1'b0; sb.push_back(e);
      wait_done();
      @(posedge clk);
      @(negedge clk); start = 1'b0;
      chk("b2b_busy", int'(ready), 0);
      wait_done();
    end

    // Reset during BUSY aborts without a done pulse.
    wait_ready();
    A = 4'd13; B = 4'd3; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    chk("hold_Q_busy", int'(Q), 3);
    chk("hold_R_busy", int'(R), 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_ready", int'(ready), 1);
    chk("abort_Q", int'(Q), 0);
    chk("abort_R", int'(R), 0);
    chk("abort_done", int'(done), 0);
    rst_n = 1'b1;
    watch_abort = 1'b1;
    repeat (10) @(negedge clk);
    watch_abort = 1'b0;
    chk("no_done_after_abort", n_done_abort, 0);

    // Sweep all nonzero divisors.
    for (int a = 0; a < 16; a++)
      for (int b = 1; b < 16; b++)
        do_div(a, b, a / b, a % b, 1'b0, 0);

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
